// File: rtl/cu_fsm_ws.sv
// rtl/cu_fsm_ws.sv - multi-cycle control unit FSM with memory wait states, interrupts and traps
// Bus timeout traps fire when the wait counter reaches MEM_TIMEOUT; a same-cycle ready always wins.
module cu_fsm_ws #(
  parameter int NUM_IRQ     = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                                        CLK,
  input  logic                                        RST_N,
  input  logic [6:0]                                  OPCODE,
  input  logic [2:0]                                  FUNCT3,
  input  logic                                        IMEM_READY,
  input  logic                                        DMEM_READY,
  input  logic [NUM_IRQ-1:0]                          IRQ,
  input  logic [NUM_IRQ-1:0]                          IRQ_MASK,
  input  logic                                        CSR_MIE,
  output logic                                        PCWRITE,
  output logic                                        regWRITE,
  output logic                                        memWE2,
  output logic                                        memRDEN1,
  output logic                                        memRDEN2,
  output logic                                        reset,
  output logic                                        csr_WE,
  output logic                                        int_taken,
  output logic                                        mret_exec,
  output logic                                        trap_taken,
  output logic [1:0]                                  trap_cause,
  output logic [((NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1)-1:0] int_id
);

  localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    INIT      = 3'd0,
    FETCH     = 3'd1,
    EXEC      = 3'd2,
    MEM_WAIT  = 3'd3,
    WRITEBACK = 3'd4,
    INTRPT    = 3'd5,
    TRAP      = 3'd6
  } state_t;

  state_t          r_state;
  state_t          w_next;
  state_t          w_done;
  logic [CW-1:0]   r_cnt;
  logic            r_is_load;
  logic [IW-1:0]   r_int_id;
  logic [1:0]      r_trap_cause;
  logic [1:0]      w_cause;
  logic [IW-1:0]   w_lowest;
  logic [NUM_IRQ-1:0] w_pending;
  logic            w_timeout;
  logic            w_waiting;

  assign w_pending = IRQ & IRQ_MASK & {NUM_IRQ{CSR_MIE}};
  assign w_done    = (|w_pending) ? INTRPT : FETCH;
  assign w_timeout = (MEM_TIMEOUT != 0) && (r_cnt == CW'(MEM_TIMEOUT));
  assign w_waiting = (r_state == FETCH) || (r_state == MEM_WAIT);

  // Scan downward so the lowest pending index is the one left standing.
  always_comb begin
    w_lowest = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_pending[i]) w_lowest = IW'(i);
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cause    = 2'b00;
    PCWRITE    = 1'b0;
    regWRITE   = 1'b0;
    memWE2     = 1'b0;
    memRDEN1   = 1'b0;
    memRDEN2   = 1'b0;
    reset      = 1'b0;
    csr_WE     = 1'b0;
    int_taken  = 1'b0;
    mret_exec  = 1'b0;
    trap_taken = 1'b0;
    case (r_state)
      INIT: begin
        reset  = 1'b1;
        w_next = FETCH;
      end
      FETCH: begin
        memRDEN1 = 1'b1;
        if (IMEM_READY) begin
          w_next = EXEC;
        end else if (w_timeout) begin
          w_next  = TRAP;
          w_cause = 2'b10;
        end
      end
      EXEC: begin
        memRDEN1 = 1'b1;
        case (OPCODE)
          OP_IMM, OP_REG, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: begin
            PCWRITE  = 1'b1;
            regWRITE = 1'b1;
            w_next   = w_done;
          end
          OP_BRANCH: begin
            PCWRITE = 1'b1;
            w_next  = w_done;
          end
          OP_LOAD: begin
            memRDEN2 = 1'b1;
            w_next   = MEM_WAIT;
          end
          OP_STORE: begin
            memWE2 = 1'b1;
            w_next = MEM_WAIT;
          end
          OP_SYSTEM: begin
            case (FUNCT3)
              3'b001, 3'b010, 3'b011: begin
                PCWRITE  = 1'b1;
                regWRITE = 1'b1;
                csr_WE   = 1'b1;
                w_next   = w_done;
              end
              3'b000: begin
                PCWRITE   = 1'b1;
                mret_exec = 1'b1;
                w_next    = w_done;
              end
              default: begin
                w_next  = TRAP;
                w_cause = 2'b01;
              end
            endcase
          end
          default: begin
            w_next  = TRAP;
            w_cause = 2'b01;
          end
        endcase
      end
      MEM_WAIT: begin
        memRDEN1 = 1'b1;
        memRDEN2 = r_is_load;
        memWE2   = ~r_is_load;
        if (DMEM_READY) begin
          if (r_is_load) begin
            w_next = WRITEBACK;
          end else begin
            PCWRITE = 1'b1;
            w_next  = w_done;
          end
        end else if (w_timeout) begin
          w_next  = TRAP;
          w_cause = 2'b10;
        end
      end
      WRITEBACK: begin
        PCWRITE  = 1'b1;
        regWRITE = 1'b1;
        memRDEN1 = 1'b1;
        memRDEN2 = 1'b1;
        w_next   = w_done;
      end
      INTRPT: begin
        PCWRITE   = 1'b1;
        int_taken = 1'b1;
        memRDEN1  = 1'b1;
        w_next    = FETCH;
      end
      TRAP: begin
        PCWRITE    = 1'b1;
        trap_taken = 1'b1;
        w_next     = FETCH;
      end
      default: w_next = INIT;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= INIT;
      r_cnt        <= '0;
      r_is_load    <= 1'b0;
      r_int_id     <= '0;
      r_trap_cause <= 2'b00;
    end else begin
      r_state <= w_next;
      // Staying in a wait state means ready was low; any transition restarts the count.
      r_cnt   <= (w_waiting && (w_next == r_state)) ? r_cnt + CW'(1) : '0;
      if (r_state == EXEC) r_is_load <= (OPCODE == OP_LOAD);
      if (w_next == INTRPT) r_int_id <= w_lowest;
      if (w_next == TRAP) r_trap_cause <= w_cause;
    end
  end

  assign int_id     = r_int_id;
  assign trap_cause = r_trap_cause;

endmodule
